// File: rtl/usr_sw_debounce.sv
// Two-flop synchronised, counter-debounced user DIP switches with a per-bit change strobe.
// Define USR_SW_EVENT_EN to add a coalescing valid/ready change-event output.
module usr_sw_debounce #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic             sys0_clk,
  input  logic             sys0_rst,
  input  logic [WIDTH-1:0] usr_sw,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_changed
`ifdef USR_SW_EVENT_EN
  ,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_data,
  output logic [WIDTH-1:0] ev_mask,
  output logic [7:0]       ev_coalesced
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] changed_r;
  logic [CW-1:0]    cnt_r     [WIDTH];
  logic [CW-1:0]    cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] flip_s;

  // Per-bit debounce counter: a bit flips only after CNT_MAX+1 consecutive mismatching edges.
  always_comb begin
    flip_s    = '0;
    cnt_nxt_s = cnt_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_r[i] == state_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        cnt_nxt_s[i] = '0;
        flip_s[i]    = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Synchronizer, debounced state, counters and the one-cycle change strobe.
  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      sync1_r   <= '0;
      sync_r    <= '0;
      state_r   <= '0;
      changed_r <= '0;
      cnt_r     <= '{default: '0};
    end else begin
      sync1_r   <= usr_sw;
      sync_r    <= sync1_r;
      state_r   <= state_r ^ flip_s;
      changed_r <= flip_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign sw_state   = state_r;
  assign sw_changed = changed_r;

`ifdef USR_SW_EVENT_EN
  logic             ev_valid_r;
  logic [WIDTH-1:0] ev_data_r;
  logic [WIDTH-1:0] ev_mask_r;
  logic [7:0]       ev_coal_r;
  logic             accept_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept_s = ev_valid_r & ev_ready;

  // Event holder: a change either opens a fresh event (idle or being accepted) or folds into the pending one.
  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      ev_valid_r <= 1'b0;
      ev_data_r  <= '0;
      ev_mask_r  <= '0;
      ev_coal_r  <= 8'd0;
    end else if (changed_r != '0) begin
      ev_valid_r <= 1'b1;
      ev_data_r  <= state_r;
      if (!ev_valid_r || accept_s) begin
        ev_mask_r <= changed_r;
        ev_coal_r <= 8'd0;
      end else begin
        ev_mask_r <= ev_mask_r | changed_r;
        ev_coal_r <= sat_inc8(ev_coal_r);
      end
    end else if (accept_s) begin
      ev_valid_r <= 1'b0;
    end else begin
      ev_valid_r <= ev_valid_r;
    end
  end

  assign ev_valid     = ev_valid_r;
  assign ev_data      = ev_data_r;
  assign ev_mask      = ev_mask_r;
  assign ev_coalesced = ev_coal_r;
`endif

endmodule

// File: tb/tb_usr_sw_debounce.sv
// Bench for usr_sw_debounce (WIDTH=8, DEBOUNCE_CNT=4); event checks compile only with USR_SW_EVENT_EN.
module tb_usr_sw_debounce;
  localparam int W   = 8;
  localparam int DC  = 4;
  localparam int LAT = 2 + DC;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] usr_sw;
  logic [W-1:0] sw_state;
  logic [W-1:0] sw_changed;
`ifdef USR_SW_EVENT_EN
  logic         ev_valid;
  logic         ev_ready;
  logic [W-1:0] ev_data;
  logic [W-1:0] ev_mask;
  logic [7:0]   ev_coalesced;
`endif

  usr_sw_debounce #(.WIDTH(W), .DEBOUNCE_CNT(DC)) dut (
    .sys0_clk   (clk),
    .sys0_rst   (rst),
    .usr_sw     (usr_sw),
    .sw_state   (sw_state),
    .sw_changed (sw_changed)
`ifdef USR_SW_EVENT_EN
    ,
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .ev_mask      (ev_mask),
    .ev_coalesced (ev_coalesced)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [W-1:0] state;
    logic [W-1:0] mask;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_state;
    logic [W-1:0] exp_mask;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a level; a nonzero mask schedules the change strobe LAT edges later.
  task automatic apply(input logic [W-1:0] v, input logic [W-1:0] m, input int hold);
    usr_sw = v;
    if (m != 8'h00) exp_q.push_back('{cyc + LAT, v, m});
    repeat (hold) @(negedge clk);
  endtask

  // Scoreboard: every change strobe must match the oldest scheduled change, on its exact cycle.
  always @(negedge clk) begin
    if (!rst && sw_changed !== 8'h00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sw_changed", {24'd0, sw_changed}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("chg_cycle", cyc, mon_e.due);
        check("chg_mask", {24'd0, sw_changed}, {24'd0, mon_e.mask});
        check("chg_state", {24'd0, sw_state}, {24'd0, mon_e.state});
      end
    end
  end

  initial begin
    vecs[0] = '{8'h01, 3,  8'h00, 8'h00};
    vecs[1] = '{8'h00, 8,  8'h00, 8'h00};
    vecs[2] = '{8'h05, 10, 8'h05, 8'h05};
    vecs[3] = '{8'h04, 3,  8'h05, 8'h00};
    vecs[4] = '{8'h05, 8,  8'h05, 8'h00};
    vecs[5] = '{8'h07, 4,  8'h05, 8'h02};
    vecs[6] = '{8'h05, 10, 8'h05, 8'h02};
    vecs[7] = '{8'hFA, 10, 8'hFA, 8'hFF};
    vecs[8] = '{8'h00, 10, 8'h00, 8'hFA};

    rst    = 1'b1;
    usr_sw = 8'h00;
`ifdef USR_SW_EVENT_EN
    ev_ready = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_sw_state", {24'd0, sw_state}, 32'd0);
    check("rst_sw_changed", {24'd0, sw_changed}, 32'd0);
`ifdef USR_SW_EVENT_EN
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].sw, vecs[i].exp_mask, vecs[i].hold);
      check($sformatf("vec%0d_state", i), {24'd0, sw_state}, {24'd0, vecs[i].exp_state});
    end

    // Coalescing: three changes fold into one pending event.
`ifdef USR_SW_EVENT_EN
    ev_ready = 1'b0;
`endif
    apply(8'h01, 8'h01, LAT);
`ifdef USR_SW_EVENT_EN
    check("ev_not_yet", {31'd0, ev_valid}, 32'd0);
    @(negedge clk);
    check("ev1_valid", {31'd0, ev_valid}, 32'd1);
    check("ev1_data", {24'd0, ev_data}, 32'h01);
    check("ev1_mask", {24'd0, ev_mask}, 32'h01);
    check("ev1_coal", {24'd0, ev_coalesced}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    apply(8'h03, 8'h02, 10);
    apply(8'h02, 8'h01, 10);
`ifdef USR_SW_EVENT_EN
    check("coal_valid", {31'd0, ev_valid}, 32'd1);
    check("coal_data", {24'd0, ev_data}, 32'h02);
    check("coal_mask", {24'd0, ev_mask}, 32'h03);
    check("coal_cnt", {24'd0, ev_coalesced}, 32'd2);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("accept_clears", {31'd0, ev_valid}, 32'd0);
`endif

    // Accept coinciding with a fresh change keeps the event alive with new content.
    apply(8'h00, 8'h02, 10);
    apply(8'h80, 8'h80, LAT);
`ifdef USR_SW_EVENT_EN
    check("pre_accept_mask", {24'd0, ev_mask}, 32'h02);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("reload_valid", {31'd0, ev_valid}, 32'd1);
    check("reload_mask", {24'd0, ev_mask}, 32'h80);
    check("reload_coal", {24'd0, ev_coalesced}, 32'd0);
    check("reload_data", {24'd0, ev_data}, 32'h80);
`else
    @(negedge clk);
`endif

    // Reset mid-debounce with an event pending, then power-up with switches high.
    apply(8'h81, 8'h00, 3);
    rst = 1'b1;
    #1;
    check("arst_sw_state", {24'd0, sw_state}, 32'd0);
    check("arst_sw_changed", {24'd0, sw_changed}, 32'd0);
`ifdef USR_SW_EVENT_EN
    check("arst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("arst_ev_mask", {24'd0, ev_mask}, 32'd0);
    check("arst_ev_data", {24'd0, ev_data}, 32'd0);
`endif
    usr_sw = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(8'hFF, 8'hFF, LAT - 1);
    check("post_rst_not_yet", {24'd0, sw_state}, 32'd0);
    repeat (3) @(negedge clk);
    check("post_rst_state", {24'd0, sw_state}, 32'hFF);
`ifdef USR_SW_EVENT_EN
    check("post_rst_ev_valid", {31'd0, ev_valid}, 32'd1);
    check("post_rst_ev_mask", {24'd0, ev_mask}, 32'hFF);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
